// File: rtl/amp_pwr_seq.sv
// -----------------------------------------------------------------------------
// amp_pwr_seq -- power-up / power-down sequencer for the external class-D amp.
//
// Power-up order:  enable -> register config (via I2C master) -> I2S start ->
//                  lock qualification -> unmute.
// Power-down order is the reverse: mute -> hold -> disable + stop I2S.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   run_req      in   level request from sys_cfg, 1 = amplifier on
//   lock         in   I2S source locked / valid audio
//   cfg_req      out  config transaction request to the I2C master
//   cfg_idx      out  [3:0] index of the config word being requested
//   cfg_ack      in   one-cycle completion pulse from the I2C master
//   cfg_err      in   qualifies cfg_ack: NACK / bus error
//   amp_nenable  out  amplifier enable, active low
//   amp_nmute    out  amplifier mute release (0 = muted)
//   i2s_en       out  gates I2S bck/ws/d0 generation
//   fault        out  fault flag, held until run_req drops
//   state_mon    out  [2:0] current state encoding for debug
//
// Every output comes straight from a flop. The next-state process decides the
// next state and timer value; the output pins are then decoded from the *next*
// state and registered, so they change on the same edge as the state.
// -----------------------------------------------------------------------------
module amp_pwr_seq #(
  parameter int T_EN_CYC     = 1024,
  parameter int T_UNMUTE_CYC = 4096,
  parameter int T_LOCK_TO    = 65535,
  parameter int CFG_WORDS    = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       lock,
  output logic       cfg_req,
  output logic [3:0] cfg_idx,
  input  logic       cfg_ack,
  input  logic       cfg_err,
  output logic       amp_nenable,
  output logic       amp_nmute,
  output logic       i2s_en,
  output logic       fault,
  output logic [2:0] state_mon
);

  typedef enum logic [2:0] {
    S_OFF         = 3'd0,
    S_EN_WAIT     = 3'd1,
    S_CONFIG      = 3'd2,
    S_LOCK_WAIT   = 3'd3,
    S_UNMUTE_WAIT = 3'd4,
    S_RUN         = 3'd5,
    S_MUTE_DOWN   = 3'd6,
    S_FAULT       = 3'd7
  } state_t;

  // Timer reload values. Loading N-1 and leaving on timer==0 gives exactly N
  // cycles between the entry edge and the exit edge.
  localparam logic [CNT_W-1:0] L_EN_LD     = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] L_UNMUTE_LD = CNT_W'(T_UNMUTE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LOCK_LD   = CNT_W'(T_LOCK_TO - 1);
  localparam logic [3:0]       L_LAST_IDX  = 4'(CFG_WORDS - 1);

  // State and output registers
  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_cfg_req;
  logic [3:0]       r_cfg_idx;
  logic             r_nenable;
  logic             r_nmute;
  logic             r_i2s_en;
  logic             r_fault;

  // Next-state values
  state_t           w_state_nx;
  logic [CNT_W-1:0] w_timer_nx;
  logic             w_cfg_req_nx;
  logic [3:0]       w_cfg_idx_nx;
  logic             w_nenable_nx;
  logic             w_nmute_nx;
  logic             w_i2s_en_nx;
  logic             w_fault_nx;

  logic             w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_dec;

  assign w_tmr_zero = (r_timer == '0);
  assign w_tmr_dec  = r_timer - CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / timer / config handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx   = r_state;
    w_timer_nx   = '0;          // timer rests at 0 outside the timed states
    w_cfg_req_nx = 1'b0;
    w_cfg_idx_nx = r_cfg_idx;

    unique case (r_state)
      S_OFF: begin
        w_cfg_idx_nx = '0;
        if (run_req) begin
          w_state_nx = S_EN_WAIT;
          w_timer_nx = L_EN_LD;
        end
      end

      S_EN_WAIT: begin
        if (!run_req) begin
          w_state_nx = S_MUTE_DOWN;
          w_timer_nx = L_EN_LD;
        end else if (w_tmr_zero) begin
          w_state_nx   = S_CONFIG;
          w_cfg_req_nx = 1'b1;
          w_cfg_idx_nx = '0;
        end else begin
          w_timer_nx = w_tmr_dec;
        end
      end

      S_CONFIG: begin
        if (r_cfg_req) begin
          // A request is on the bus: it must be seen through to its ack even
          // if run_req has dropped, so the I2C master is never left hanging.
          w_cfg_req_nx = 1'b1;
          if (cfg_ack) begin
            w_cfg_req_nx = 1'b0;
            if (!run_req) begin
              // shutting down: result of the last transaction is ignored
              w_state_nx = S_MUTE_DOWN;
              w_timer_nx = L_EN_LD;
            end else if (cfg_err) begin
              w_state_nx = S_FAULT;
            end else if (r_cfg_idx == L_LAST_IDX) begin
              w_state_nx = S_LOCK_WAIT;
              w_timer_nx = L_LOCK_LD;
            end else begin
              // idx advances while req is low; one idle cycle between requests
              w_cfg_idx_nx = r_cfg_idx + 4'd1;
            end
          end
        end else begin
          // idle gap between requests; acks seen here are ignored
          if (!run_req) begin
            w_state_nx = S_MUTE_DOWN;
            w_timer_nx = L_EN_LD;
          end else begin
            w_cfg_req_nx = 1'b1;
          end
        end
      end

      S_LOCK_WAIT: begin
        if (!run_req) begin
          w_state_nx = S_MUTE_DOWN;
          w_timer_nx = L_EN_LD;
        end else if (lock) begin
          w_state_nx = S_UNMUTE_WAIT;
          w_timer_nx = L_UNMUTE_LD;
        end else if (w_tmr_zero) begin
          w_state_nx = S_FAULT;
        end else begin
          w_timer_nx = w_tmr_dec;
        end
      end

      S_UNMUTE_WAIT: begin
        if (!run_req) begin
          w_state_nx = S_MUTE_DOWN;
          w_timer_nx = L_EN_LD;
        end else if (!lock) begin
          // lock must be held continuously; any drop restarts qualification
          w_state_nx = S_LOCK_WAIT;
          w_timer_nx = L_LOCK_LD;
        end else if (w_tmr_zero) begin
          w_state_nx = S_RUN;
        end else begin
          w_timer_nx = w_tmr_dec;
        end
      end

      S_RUN: begin
        if (!run_req) begin
          w_state_nx = S_MUTE_DOWN;
          w_timer_nx = L_EN_LD;
        end else if (!lock) begin
          w_state_nx = S_LOCK_WAIT;
          w_timer_nx = L_LOCK_LD;
        end
      end

      S_MUTE_DOWN: begin
        // run_req is deliberately ignored: shutdown always completes to OFF
        if (w_tmr_zero) begin
          w_state_nx = S_OFF;
        end else begin
          w_timer_nx = w_tmr_dec;
        end
      end

      S_FAULT: begin
        if (!run_req) begin
          w_state_nx = S_OFF;
        end
      end

      default: begin
        w_state_nx = S_OFF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pin decode from the next state. Unmute is possible only in RUN, and RUN is
  // reached only through LOCK_WAIT/UNMUTE_WAIT, so enable and I2S are already
  // on whenever amp_nmute is 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nenable_nx = (w_state_nx == S_OFF) || (w_state_nx == S_FAULT);
    w_nmute_nx   = (w_state_nx == S_RUN);
    w_fault_nx   = (w_state_nx == S_FAULT);
    w_i2s_en_nx  = 1'b0;
    unique case (w_state_nx)
      S_LOCK_WAIT, S_UNMUTE_WAIT, S_RUN: w_i2s_en_nx = 1'b1;
      // keep the clocks running through the mute ramp if they were running
      S_MUTE_DOWN:                       w_i2s_en_nx = r_i2s_en;
      default:                           w_i2s_en_nx = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_OFF;
      r_timer   <= '0;
      r_cfg_req <= 1'b0;
      r_cfg_idx <= '0;
      r_nenable <= 1'b1;
      r_nmute   <= 1'b0;
      r_i2s_en  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_timer   <= w_timer_nx;
      r_cfg_req <= w_cfg_req_nx;
      r_cfg_idx <= w_cfg_idx_nx;
      r_nenable <= w_nenable_nx;
      r_nmute   <= w_nmute_nx;
      r_i2s_en  <= w_i2s_en_nx;
      r_fault   <= w_fault_nx;
    end
  end

  assign cfg_req     = r_cfg_req;
  assign cfg_idx     = r_cfg_idx;
  assign amp_nenable = r_nenable;
  assign amp_nmute   = r_nmute;
  assign i2s_en      = r_i2s_en;
  assign fault       = r_fault;
  assign state_mon   = r_state;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed bench for amp_pwr_seq with short timing parameters.
module tb_amp_pwr_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_req, lock, cfg_ack, cfg_err;
  logic       cfg_req, amp_nenable, amp_nmute, i2s_en, fault;
  logic [3:0] cfg_idx;
  logic [2:0] state_mon;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  amp_pwr_seq #(
    .T_EN_CYC(8), .T_UNMUTE_CYC(16), .T_LOCK_TO(32), .CFG_WORDS(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .lock(lock),
    .cfg_req(cfg_req), .cfg_idx(cfg_idx), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .amp_nenable(amp_nenable), .amp_nmute(amp_nmute), .i2s_en(i2s_en),
    .fault(fault), .state_mon(state_mon)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // step one clock, land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 cfg_req==1, 1 amp_nmute==1, 2 amp_nenable==1, 3 state_mon==FAULT
  task automatic count_until(input int sel, output int cnt);
    logic hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < 200) begin
      tick();
      cnt++;
      case (sel)
        0: hit = cfg_req;
        1: hit = amp_nmute;
        2: hit = amp_nenable;
        default: hit = (state_mon == 3'd7);
      endcase
    end
  endtask

  // entered with cfg_req high; ack 3 cycles after the request was seen
  task automatic serve(input int idx, input logic err, input logic last);
    chk("req_idx", 32'(cfg_idx), idx);
    repeat (2) begin
      tick();
      chk("req_hold", 32'(cfg_req), 1);
      chk("idx_hold", 32'(cfg_idx), idx);
    end
    cfg_ack = 1'b1;
    cfg_err = err;
    tick();
    cfg_ack = 1'b0;
    cfg_err = 1'b0;
    chk("req_drop", 32'(cfg_req), 0);
    if (!err) begin
      if (!last) begin
        chk("i2s_off_cfg", 32'(i2s_en), 0);
        tick();
        chk("req_rearm", 32'(cfg_req), 1);
      end else begin
        chk("i2s_on", 32'(i2s_en), 1);
        chk("st_lock_wait", 32'(state_mon), 3);
      end
    end
  endtask

  initial begin
    reset = 1'b1; run_req = 1'b0; lock = 1'b0; cfg_ack = 1'b0; cfg_err = 1'b0;

    // ---- reset values
    tick(); tick();
    chk("rst_state", 32'(state_mon), 0);
    chk("rst_nen", 32'(amp_nenable), 1);
    chk("rst_nmute", 32'(amp_nmute), 0);
    chk("rst_i2s", 32'(i2s_en), 0);
    chk("rst_req", 32'(cfg_req), 0);
    chk("rst_idx", 32'(cfg_idx), 0);
    chk("rst_fault", 32'(fault), 0);
    #3 reset = 1'b0;
    tick();
    chk("off_idle", 32'(state_mon), 0);

    // ---- nominal power-up
    lock = 1'b1;
    run_req = 1'b1;
    tick();
    chk("nen_fall", 32'(amp_nenable), 0);
    chk("st_en_wait", 32'(state_mon), 1);
    count_until(0, n);
    chk("en_to_req", n, 8);
    chk("st_config", 32'(state_mon), 2);
    for (int i = 0; i < 4; i++) serve(i, 1'b0, i == 3);
    tick();
    chk("st_unmute_wait", 32'(state_mon), 4);
    count_until(1, n);
    chk("unmute_delay", n, 16);
    chk("st_run", 32'(state_mon), 5);
    chk("run_nen", 32'(amp_nenable), 0);
    chk("run_i2s", 32'(i2s_en), 1);

    // ---- one-cycle lock drop in RUN
    lock = 1'b0;
    tick();
    chk("drop_nmute", 32'(amp_nmute), 0);
    chk("drop_state", 32'(state_mon), 3);
    chk("drop_i2s", 32'(i2s_en), 1);
    chk("drop_nen", 32'(amp_nenable), 0);
    lock = 1'b1;
    tick();
    chk("relock_state", 32'(state_mon), 4);
    count_until(1, n);
    chk("relock_delay", n, 16);

    // ---- shutdown from RUN
    run_req = 1'b0;
    tick();
    chk("md_state", 32'(state_mon), 6);
    chk("md_nmute", 32'(amp_nmute), 0);
    chk("md_nen", 32'(amp_nenable), 0);
    count_until(2, n);
    chk("md_to_off", n, 8);
    chk("off_state", 32'(state_mon), 0);
    chk("off_i2s", 32'(i2s_en), 0);

    // ---- config NACK on idx 2
    run_req = 1'b1;
    count_until(0, n);
    chk("req_latency2", n, 9);
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);
    serve(2, 1'b1, 1'b0);
    chk("nack_state", 32'(state_mon), 7);
    chk("nack_fault", 32'(fault), 1);
    chk("nack_nen", 32'(amp_nenable), 1);
    chk("nack_nmute", 32'(amp_nmute), 0);
    n = 0;
    repeat (4) begin tick(); n += int'(cfg_req); end
    chk("nack_no_req", n, 0);
    chk("fault_sticky", 32'(fault), 1);
    run_req = 1'b0;
    tick();
    chk("fault_exit_state", 32'(state_mon), 0);
    chk("fault_cleared", 32'(fault), 0);

    // ---- shutdown with a request outstanding
    run_req = 1'b1;
    count_until(0, n);
    chk("req_latency3", n, 9);
    run_req = 1'b0;
    repeat (4) begin
      tick();
      chk("sd_req_hold", 32'(cfg_req), 1);
      chk("sd_cfg_state", 32'(state_mon), 2);
    end
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    chk("sd_md_state", 32'(state_mon), 6);
    chk("sd_req_drop", 32'(cfg_req), 0);
    count_until(2, n);
    chk("sd_md_to_off", n, 8);

    // ---- lock timeout
    lock = 1'b0;
    run_req = 1'b1;
    count_until(0, n);
    for (int i = 0; i < 4; i++) serve(i, 1'b0, i == 3);
    count_until(3, n);
    chk("lock_timeout", n, 32);
    chk("to_fault", 32'(fault), 1);
    chk("to_i2s", 32'(i2s_en), 0);
    run_req = 1'b0;
    tick();
    chk("to_exit", 32'(state_mon), 0);

    // ---- async reset in UNMUTE_WAIT, between edges
    lock = 1'b1;
    run_req = 1'b1;
    count_until(0, n);
    for (int i = 0; i < 4; i++) serve(i, 1'b0, i == 3);
    tick();
    tick();
    chk("ar_pre_state", 32'(state_mon), 4);
    #3 reset = 1'b1;
    #1;
    chk("ar_state", 32'(state_mon), 0);
    chk("ar_nen", 32'(amp_nenable), 1);
    chk("ar_nmute", 32'(amp_nmute), 0);
    chk("ar_i2s", 32'(i2s_en), 0);
    chk("ar_req", 32'(cfg_req), 0);
    chk("ar_idx", 32'(cfg_idx), 0);
    chk("ar_fault", 32'(fault), 0);
    tick();
    reset = 1'b0;
    run_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
